// File: rtl/fifo_ctrl.sv
// Pointer and status controller for a synchronous FIFO whose register file has an async read port.
// Optional sticky overflow/underflow flags are built when FIFO_CTRL_ERR_FLAGS_EN is defined.
module fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 1,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] w_ptr_q, w_ptr_d;
  logic [PW-1:0] r_ptr_q, r_ptr_d;
  logic [PW-1:0] count_c;
  logic          full_c, empty_c, wr_ok_c, rd_ok_c;

  // Status derived only from the registered pointers; the MSB is the wrap bit.
  always_comb begin
    empty_c = (w_ptr_q == r_ptr_q);
    full_c  = (w_ptr_q[ADDR_WIDTH] != r_ptr_q[ADDR_WIDTH]) &&
              (w_ptr_q[ADDR_WIDTH-1:0] == r_ptr_q[ADDR_WIDTH-1:0]);
    count_c = w_ptr_q - r_ptr_q;
  end

  // A write to a full FIFO is legal when a read frees the same slot at the same edge.
  always_comb begin
    wr_ok_c = wr & (~full_c | rd);
    rd_ok_c = rd & ~empty_c;
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (wr_ok_c) begin
      w_ptr_d = w_ptr_q + PW'(1);
    end
    if (rd_ok_c) begin
      r_ptr_d = r_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
    end
  end

  assign w_en         = wr_ok_c;
  assign w_addr       = w_ptr_q[ADDR_WIDTH-1:0];
  assign r_addr       = r_ptr_q[ADDR_WIDTH-1:0];
  assign full         = full_c;
  assign empty        = empty_c;
  assign count        = count_c;
  assign almost_full  = (count_c >= PW'(AF_THRESH));
  assign almost_empty = (count_c <= PW'(AE_THRESH));

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A simultaneous write turns a read of an empty FIFO into a plain write, so it is not an underflow.
  always_comb begin
    ovf_d = ovf_q | (wr & full_c & ~rd);
    unf_d = unf_q | (rd & empty_c & ~wr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: vector table for pointer/flag behaviour plus data, wrap and reset sequences.
module tb_fifo_ctrl;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, wr, rd;
  logic       w_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] w_addr, r_addr;
  logic [3:0] count;
  logic [7:0] w_data;
  logic [7:0] mem [8];
  logic [7:0] r_data;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       w_en;
    logic [3:0] cnt;
    logic [2:0] wa;
    logic [2:0] ra;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] sb[$];

  fifo_ctrl #(.ADDR_WIDTH(3), .AF_THRESH(7), .AE_THRESH(1)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .w_en(w_en),
    .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Register file the controller drives: edge-triggered write, asynchronous read.
  always @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end
  assign r_data = mem[r_addr];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void add(input logic w, input logic r, input logic we,
                              input int c, input int wa, input int ra);
    vec_t v;
    v.wr = w; v.rd = r; v.w_en = we;
    v.cnt = 4'(c); v.wa = 3'(wa); v.ra = 3'(ra);
    v.full = (c == 8); v.empty = (c == 0);
    v.af = (c >= 7); v.ae = (c <= 1);
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_ae"}, almost_empty, 1);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_waddr"}, w_addr, 0);
    chk({tag, "_raddr"}, r_addr, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_unf"}, underflow, 0);
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
    // Expected state after each edge; w_en is the pre-edge combinational value.
    for (int i = 1; i <= 8; i++) add(1, 0, 1, i, i, 0);
    add(1, 0, 0, 8, 0, 0);
    add(1, 1, 1, 8, 1, 1);
    add(1, 1, 1, 8, 2, 2);
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 8 - i, 2, 2 + i);
    add(0, 1, 0, 0, 2, 2);
    add(1, 1, 1, 1, 3, 2);
    add(0, 0, 0, 1, 3, 2);
    add(1, 1, 1, 1, 4, 3);

    #3 chk_idle("reset");
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      wr = vecs[i].wr; rd = vecs[i].rd; w_data = 8'(i);
      #1 chk($sformatf("v%0d_w_en", i), w_en, vecs[i].w_en);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("v%0d_waddr", i), w_addr, vecs[i].wa);
      chk($sformatf("v%0d_raddr", i), r_addr, vecs[i].ra);
      chk($sformatf("v%0d_full", i), full, vecs[i].full);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].empty);
      chk($sformatf("v%0d_af", i), almost_full, vecs[i].af);
      chk($sformatf("v%0d_ae", i), almost_empty, vecs[i].ae);
    end
    chk("table_ovf", overflow, int'(ERR_EN));
    chk("table_unf", underflow, int'(ERR_EN));

    // Fill with 0x10..0x17, then 20 simultaneous read/write cycles while full, then drain.
    do_reset();
    #1 chk_idle("rstA");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr = 1'b1; rd = 1'b0; w_data = 8'h10 + 8'(i);
      sb.push_back(w_data);
    end
    @(negedge clk);
    wr = 1'b1; rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w_data = 8'h20 + 8'(i);
      #1;
      chk($sformatf("ff%0d_w_en", i), w_en, 1);
      chk($sformatf("ff%0d_rdata", i), r_data, sb.pop_front());
      sb.push_back(w_data);
      @(posedge clk);
      #1;
      chk($sformatf("ff%0d_full", i), full, 1);
      chk($sformatf("ff%0d_count", i), count, 8);
      @(negedge clk);
    end
    chk("ff_waddr", w_addr, 4);
    chk("ff_raddr", r_addr, 4);
    wr = 1'b0; rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("drain%0d_rdata", i), r_data, sb.pop_front());
      @(posedge clk);
      #1 chk($sformatf("drain%0d_count", i), count, 7 - i);
      @(negedge clk);
    end
    rd = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_ae", almost_empty, 1);

    // Read and write together on an empty FIFO: only the write takes effect.
    do_reset();
    @(negedge clk);
    wr = 1'b1; rd = 1'b1; w_data = 8'hA5;
    @(posedge clk);
    #1;
    chk("rw_empty_count", count, 1);
    chk("rw_empty_raddr", r_addr, 0);
    chk("rw_empty_rdata", r_data, 8'hA5);
    chk("rw_empty_unf", underflow, 0);
    @(negedge clk) begin wr = 1'b0; rd = 1'b0; end

    // Asynchronous reset between edges after 5 writes.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr = 1'b1; rd = 1'b0; w_data = 8'h30 + 8'(i);
    end
    @(negedge clk);
    wr = 1'b0;
    chk("pre_rst_count", count, 5);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_empty", empty, 1);
    chk("async_rst_count", count, 0);
    chk("async_rst_waddr", w_addr, 0);
    reset = 1'b0;
    @(negedge clk);
    wr = 1'b1; w_data = 8'h5A;
    #1;
    chk("post_rst_w_en", w_en, 1);
    chk("post_rst_waddr", w_addr, 0);
    @(posedge clk);
    #1;
    chk("post_rst_count", count, 1);
    chk("post_rst_rdata", r_data, 8'h5A);
    @(negedge clk) wr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
